conv2d_pipe: RTL and testbench
==============================

Name: conv2d_pipe

Overview:
- Parametrised, pipelined successor of the 3x3 column-streamed convolver.
- Accepts one packed M_LEN-pixel image or kernel column per valid cycle and keeps an M_LEN x M_LEN sliding window.
- Computes a signed MAC over the window through a registered multiply / adder-tree / scaling pipeline.
- Emits offset-binary results with an explicit output valid; sits between the line-buffer reader and the output frame writer.

Parameters:
- BIT_LEN, 8: signed pixel and kernel coefficient width.
- M_LEN, 3: window side; odd, legal values 3..7.
- ACC_LEN, 20: accumulator width; must be >= 2*BIT_LEN + clog2(M_LEN*M_LEN).
- OUT_LEN, 13: output width.
- OUT_SHIFT, 7: arithmetic right shift applied to the accumulator before output.

Ports:
- CLK100MHZ  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous reset, active-low (0 = reset).
- i_data  in  M_LEN*BIT_LEN  packed column; row r occupies bits [(r+1)*BIT_LEN-1 -: BIT_LEN].
- i_selecK_I  in  1  1 = image column, 0 = kernel column.
- i_valid  in  1  column accepted this cycle.
- o_data  out  OUT_LEN  offset-binary convolution result.
- o_valid  out  1  one-cycle pulse per completed result.

Behaviour:
- Storage: kernel[M_LEN] and image[M_LEN] column registers. An accepted column shifts in at index M_LEN-1; index 0 is discarded.
- Reset values (async, i_reset=0):
  - image = 0.
  - kernel = 0 except centre tap = 2^(BIT_LEN-2) (scaled identity).
  - state = FILL, fill_cnt = 0, pipeline valids = 0.
  - o_valid = 0; o_data = {1'b1, 0...} (0x1000 at defaults).
- FSM states: FILL, RUN, KLOAD.
  - FILL: each accepted image column increments fill_cnt. The column that brings fill_cnt to M_LEN enters RUN and issues a window.
  - RUN: each accepted image column issues a window.
  - Any state, accepted kernel column: go to KLOAD, clear fill_cnt, shift the kernel. Windows already in flight drain using the products captured earlier.
  - KLOAD: first accepted image column goes to FILL with fill_cnt = 1.
- Stall: i_valid=0 holds all state, windows and counters. The pipeline keeps draining independently of i_valid.
- Pipeline, latency 3 cycles from the accepting edge to o_valid:
  - S1: register all M_LEN^2 signed products, 2*BIT_LEN bits each.
  - S2: register the sign-extended sum, ACC_LEN bits.
  - S3: register o_data and o_valid.
- Output: scaled = acc >>> OUT_SHIFT. o_data = low OUT_LEN bits of scaled, with the MSB inverted.
- When o_valid=0, o_data holds its last value.
- One window per accepted image column in RUN gives full throughput: one result per cycle.
- Reset asserted mid-operation clears everything immediately, including in-flight results; none are emitted after reset release.

Optional Feature:
- CONV_SAT_EN defined: before MSB inversion, scaled is clamped to [-2^(OUT_LEN-1), 2^(OUT_LEN-1)-1].
- CONV_SAT_EN undefined: plain truncation, which wraps on overflow.

Test Plan:
- Reset, then 3 image columns i_data=0x020202 on consecutive cycles -> single o_valid 3 cycles after the third column; o_data=0x1001.
- Load kernel columns 0x010101 x3, then image columns 0x7F7F7F x3 -> o_data=0x1008; continued image columns give o_valid every cycle with o_data=0x1008.
- Kernel columns 0x808080 x3, image columns 0x7F7F7F x3 -> acc=-146304, o_data=0x0B89.
- Bench override OUT_SHIFT=2, kernel 0x808080 and image 0x808080 -> acc=147456; with CONV_SAT_EN o_data=0x1FFF, without it o_data=0x0000.
- i_valid gaps of 1-4 cycles between image columns in FILL -> exactly one o_valid, 3 cycles after the third accepted column; a kernel column inserted in RUN -> no further o_valid until 3 new image columns are accepted.
- i_reset pulled low mid-RUN with 2 results in flight -> o_valid=0 and o_data=0x1000 immediately; no o_valid after release until 3 new image columns are accepted.

Source files
------------

// File: rtl/conv2d_pipe.sv
// conv2d_pipe: M_LEN x M_LEN column-streamed signed convolver, 3-stage MAC pipe.
// Define CONV_SAT_EN to clamp the scaled result instead of wrapping it.
module conv2d_pipe #(
  parameter int BIT_LEN   = 8,
  parameter int M_LEN     = 3,
  parameter int ACC_LEN   = 20,
  parameter int OUT_LEN   = 13,
  parameter int OUT_SHIFT = 7
) (
  input  logic                     CLK100MHZ,
  input  logic                     i_reset,
  input  logic [M_LEN*BIT_LEN-1:0] i_data,
  input  logic                     i_selecK_I,
  input  logic                     i_valid,
  output logic [OUT_LEN-1:0]       o_data,
  output logic                     o_valid
);

  localparam int W  = M_LEN * BIT_LEN;
  localparam int NP = M_LEN * M_LEN;
  localparam int PW = 2 * BIT_LEN;
  localparam int CW = $clog2(M_LEN + 1);

  localparam logic [W-1:0] KCTR =
    W'(1) << ((M_LEN / 2) * BIT_LEN + BIT_LEN - 2);
  localparam logic [OUT_LEN-1:0] OMSB =
    OUT_LEN'(1) << (OUT_LEN - 1);

  typedef enum logic [1:0] {
    FILL,
    RUN,
    KLOAD
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] fill_cnt, fill_nx;
  logic          issue, issue_q;
  logic          img_acc, krn_acc;

  assign img_acc = i_valid & i_selecK_I;
  assign krn_acc = i_valid & ~i_selecK_I;

  always_ff @(posedge CLK100MHZ or negedge i_reset) begin
    if (!i_reset) begin
      state    <= FILL;
      fill_cnt <= '0;
      issue_q  <= 1'b0;
    end else begin
      state    <= state_nx;
      fill_cnt <= fill_nx;
      issue_q  <= issue;
    end
  end

  always_comb begin
    state_nx = state;
    fill_nx  = fill_cnt;
    issue    = 1'b0;
    unique case (1'b1)
      krn_acc: begin
        state_nx = KLOAD;
        fill_nx  = '0;
      end
      img_acc: begin
        case (state)
          FILL: begin
            fill_nx = fill_cnt + CW'(1);
            if (fill_cnt == CW'(M_LEN - 1)) begin
              state_nx = RUN;
              issue    = 1'b1;
            end
          end
          RUN: issue = 1'b1;
          KLOAD: begin
            state_nx = FILL;
            fill_nx  = CW'(1);
          end
          default: state_nx = FILL;
        endcase
      end
      default: ;
    endcase
  end

  logic [W-1:0] img [M_LEN];
  logic [W-1:0] krn [M_LEN];

  always_ff @(posedge CLK100MHZ or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < M_LEN; i++) begin
        img[i] <= '0;
        krn[i] <= (i == M_LEN / 2) ? KCTR : '0;
      end
    end else if (img_acc) begin
      for (int i = 0; i < M_LEN - 1; i++)
        img[i] <= img[i+1];
      img[M_LEN-1] <= i_data;
    end else if (krn_acc) begin
      for (int i = 0; i < M_LEN - 1; i++)
        krn[i] <= krn[i+1];
      krn[M_LEN-1] <= i_data;
    end
  end

  // S1 samples the window one edge after issue, before any later kernel shift
  logic signed [PW-1:0] prod [NP];
  logic                 v1;

  always_ff @(posedge CLK100MHZ or negedge i_reset) begin
    if (!i_reset) begin
      v1 <= 1'b0;
      for (int i = 0; i < NP; i++)
        prod[i] <= '0;
    end else begin
      v1 <= issue_q;
      if (issue_q) begin
        for (int c = 0; c < M_LEN; c++)
          for (int r = 0; r < M_LEN; r++)
            prod[c*M_LEN+r] <=
              PW'($signed(img[c][r*BIT_LEN +: BIT_LEN])) *
              PW'($signed(krn[c][r*BIT_LEN +: BIT_LEN]));
      end
    end
  end

  logic signed [ACC_LEN-1:0] sum_c, acc_q;
  logic                      v2;

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < NP; i++)
      sum_c = sum_c + ACC_LEN'(prod[i]);
  end

  always_ff @(posedge CLK100MHZ or negedge i_reset) begin
    if (!i_reset) begin
      v2    <= 1'b0;
      acc_q <= '0;
    end else begin
      v2 <= v1;
      if (v1)
        acc_q <= sum_c;
    end
  end

  logic [OUT_LEN-1:0] res_c;

`ifdef CONV_SAT_EN
  localparam logic signed [ACC_LEN-1:0] SMAX =
    ACC_LEN'((64'sd1 <<< (OUT_LEN - 1)) - 64'sd1);
  localparam logic signed [ACC_LEN-1:0] SMIN = ~SMAX;

  logic signed [ACC_LEN-1:0] scaled, sat;

  always_comb begin
    scaled = acc_q >>> OUT_SHIFT;
    sat    = scaled;
    if (scaled > SMAX)
      sat = SMAX;
    else if (scaled < SMIN)
      sat = SMIN;
    res_c = OUT_LEN'(sat) ^ OMSB;
  end
`else
  always_comb begin
    res_c = OUT_LEN'(acc_q >>> OUT_SHIFT) ^ OMSB;
  end
`endif

  always_ff @(posedge CLK100MHZ or negedge i_reset) begin
    if (!i_reset) begin
      o_valid <= 1'b0;
      o_data  <= OMSB;
    end else begin
      o_valid <= v2;
      if (v2)
        o_data <= res_c;
    end
  end

endmodule

// File: tb/tb_conv2d_pipe.sv
// tb_conv2d_pipe: directed bench for conv2d_pipe with a window-level model.
// Two instances share stimulus: default scaling and OUT_SHIFT=2.
module tb_conv2d_pipe;

  localparam int W  = 24;
  localparam int OL = 13;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  din   = '0;
  logic          sel   = 1'b0;
  logic          vld   = 1'b0;
  logic [OL-1:0] oa, ob;
  logic          va, vb;

  always #5 clk = ~clk;

  conv2d_pipe #(
    .BIT_LEN(8), .M_LEN(3), .ACC_LEN(20),
    .OUT_LEN(13), .OUT_SHIFT(7)
  ) dut_a (
    .CLK100MHZ (clk),
    .i_reset   (rst_n),
    .i_data    (din),
    .i_selecK_I(sel),
    .i_valid   (vld),
    .o_data    (oa),
    .o_valid   (va)
  );

  conv2d_pipe #(
    .BIT_LEN(8), .M_LEN(3), .ACC_LEN(20),
    .OUT_LEN(13), .OUT_SHIFT(2)
  ) dut_b (
    .CLK100MHZ (clk),
    .i_reset   (rst_n),
    .i_data    (din),
    .i_selecK_I(sel),
    .i_valid   (vld),
    .o_data    (ob),
    .o_valid   (vb)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int na = 0, nb = 0, cap_a = 0, cap_b = 0, vcyc = 0;

  typedef struct {
    int due;
    int da;
    int db;
  } exp_t;

  exp_t q[$];
  exp_t e;
  bit   ev;
  int   exp_a = 'h1000;
  int   exp_b = 'h1000;
  int   mimg[3][3];
  int   mkrn[3][3];
  int   nimg;

  task automatic chk(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  function automatic int fmt(longint acc, int sh);
    longint s;
    s = acc >>> sh;
`ifdef CONV_SAT_EN
    if (s > 4095) s = 4095;
    if (s < -4096) s = -4096;
`endif
    return int'((s & 64'h1FFF) ^ 64'h1000);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++) begin
        mimg[c][r] = 0;
        mkrn[c][r] = 0;
      end
    mkrn[1][1] = 64;
    nimg  = 0;
    q.delete();
    exp_a = 'h1000;
    exp_b = 'h1000;
  endtask

  // A window exists once three image columns follow the last kernel column
  task automatic model_accept(logic s, logic [W-1:0] d);
    int     col[3];
    longint acc;
    exp_t   x;
    for (int r = 0; r < 3; r++)
      col[r] = int'($signed(d[r*8 +: 8]));
    if (s) begin
      mimg[0] = mimg[1];
      mimg[1] = mimg[2];
      mimg[2] = col;
      if (nimg < 3) nimg++;
      if (nimg == 3) begin
        acc = 0;
        for (int c = 0; c < 3; c++)
          for (int r = 0; r < 3; r++)
            acc += longint'(mimg[c][r]) * longint'(mkrn[c][r]);
        x.due = cyc + 3;
        x.da  = fmt(acc, 7);
        x.db  = fmt(acc, 2);
        q.push_back(x);
      end
    end else begin
      mkrn[0] = mkrn[1];
      mkrn[1] = mkrn[2];
      mkrn[2] = col;
      nimg = 0;
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      ev = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        ev    = 1'b1;
        e     = q.pop_front();
        exp_a = e.da;
        exp_b = e.db;
      end
      chk("valid_a", int'(va), int'(ev));
      chk("valid_b", int'(vb), int'(ev));
      chk("data_a", int'(oa), exp_a);
      chk("data_b", int'(ob), exp_b);
      if (va) begin
        na++;
        cap_a = int'(oa);
        vcyc  = cyc;
      end
      if (vb) begin
        nb++;
        cap_b = int'(ob);
      end
    end
  end

  task automatic drive(logic v, logic s, logic [W-1:0] d);
    vld = v;
    sel = s;
    din = d;
    @(posedge clk);
    #1;
    if (v && rst_n) model_accept(s, d);
  endtask

  task automatic img(logic [W-1:0] d);
    drive(1'b1, 1'b1, d);
  endtask

  task automatic krn(logic [W-1:0] d);
    drive(1'b1, 1'b0, d);
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 1'b1, 24'h0);
  endtask

  task automatic do_reset();
    vld   = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_a", int'(va), 0);
    chk("rst_data_a", int'(oa), 'h1000);
    chk("rst_valid_b", int'(vb), 0);
    chk("rst_data_b", int'(ob), 'h1000);
    rst_n = 1'b1;
  endtask

  initial begin
    int a0, b0, t3;

    model_reset();
    do_reset();

    a0 = na; b0 = nb;
    img(24'h020202);
    img(24'h020202);
    img(24'h020202);
    t3 = cyc;
    idle(5);
    chk("t1_count_a", na - a0, 1);
    chk("t1_count_b", nb - b0, 1);
    chk("t1_latency", vcyc - t3, 3);
    chk("t1_data_a", cap_a, 'h1001);
    chk("t1_data_b", cap_b, 'h1020);

    a0 = na;
    repeat (3) krn(24'h010101);
    repeat (6) img(24'h7F7F7F);
    idle(5);
    chk("t2_count", na - a0, 4);
    chk("t2_data_a", cap_a, 'h1008);
    chk("t2_data_b", cap_b, 'h111D);

    repeat (3) krn(24'h808080);
    repeat (3) img(24'h7F7F7F);
    idle(5);
    chk("t3_data_a", cap_a, 'h0B89);

    repeat (3) krn(24'h808080);
    repeat (3) img(24'h808080);
    idle(5);
    chk("t4_data_a", cap_a, 'h1480);
`ifdef CONV_SAT_EN
    chk("t4_data_b", cap_b, 'h1FFF);
`else
    chk("t4_data_b", cap_b, 'h0000);
`endif

    repeat (3) krn(24'h010101);
    a0 = na;
    img(24'h020202);
    idle(1);
    img(24'h020202);
    idle(4);
    img(24'h020202);
    t3 = cyc;
    idle(6);
    chk("t5_gap_count", na - a0, 1);
    chk("t5_gap_latency", vcyc - t3, 3);

    img(24'h020202);
    img(24'h020202);
    krn(24'h020202);
    idle(4);
    chk("t5_drain_b", cap_b, 'h1004);
    a0 = na;
    img(24'h020202);
    img(24'h020202);
    idle(5);
    chk("t5_kload_none", na - a0, 0);
    img(24'h020202);
    idle(4);
    chk("t5_kload_one", na - a0, 1);

    repeat (3) img(24'h7F7F7F);
    idle(1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid_a", int'(va), 0);
    chk("t6_async_data_a", int'(oa), 'h1000);
    chk("t6_async_valid_b", int'(vb), 0);
    chk("t6_async_data_b", int'(ob), 'h1000);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    a0 = na;
    idle(6);
    img(24'h7F7F7F);
    img(24'h7F7F7F);
    idle(5);
    chk("t6_no_stale", na - a0, 0);
    img(24'h7F7F7F);
    t3 = cyc;
    idle(5);
    chk("t6_count", na - a0, 1);
    chk("t6_latency", vcyc - t3, 3);
    chk("t6_data_a", cap_a, 'h103F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
